// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray sequence generator.
package gray_seq_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Works for any width up to 32; callers cast the result down to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Sticky checker: consecutive transferred Gray words must differ in exactly one bit.
// Used by gray_seq_gen only when GRAY_STEP_CHECK_EN is defined.
module gray_step_checker
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             xfer,
  input  logic [WIDTH-1:0] gray,
  output logic             err
);

  logic [WIDTH-1:0] prev;
  logic             have_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev      <= '0;
      have_prev <= 1'b0;
      err       <= 1'b0;
    end else if (clear) begin
      have_prev <= 1'b0;
      err       <= 1'b0;
    end else if (xfer) begin
      // The first word of a sequence has no predecessor to compare against.
      if (have_prev && ($countones(prev ^ gray) != 1)) begin
        err <= 1'b1;
      end
      prev      <= gray;
      have_prev <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_seq_gen.sv
// Up/down binary count source with registered Gray output on a valid/ready stream.
// Optional Gray single-step checker enabled by macro GRAY_STEP_CHECK_EN.
module gray_seq_gen
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH:0]   len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH:0]   remaining, remaining_nxt;
  logic             up_q, up_nxt;
  logic             xfer;

  // Abort wins over a same-cycle handshake, so that word is not counted.
  assign xfer = (state == RUN) && out_ready && !abort;

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    remaining_nxt = remaining;
    up_nxt        = up_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_nxt     = RUN;
            count_nxt     = seed;
            remaining_nxt = len;
            up_nxt        = dir;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (xfer) begin
          if (remaining == (WIDTH+1)'(1)) begin
            state_nxt = DONE;
          end else begin
            remaining_nxt = remaining - (WIDTH+1)'(1);
            count_nxt     = up_q ? count + WIDTH'(1) : count - WIDTH'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      gray_q    <= '0;
      remaining <= '0;
      up_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      gray_q    <= WIDTH'(bin2gray(32'(count_nxt)));
      remaining <= remaining_nxt;
      up_q      <= up_nxt;
    end
  end

  assign out_valid = (state == RUN);
  assign out_bin   = count;
  assign out_gray  = gray_q;
  assign out_last  = (state == RUN) && (remaining == (WIDTH+1)'(1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

`ifdef GRAY_STEP_CHECK_EN
  logic start_acc;
  assign start_acc = (state == IDLE) && start;

  gray_step_checker #(.WIDTH(WIDTH)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_acc),
    .xfer  (xfer),
    .gray  (gray_q),
    .err   (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule
